// File: rtl/pmem_loader_pkg.sv
// Shared definitions for the program-memory loader: state encodings and frame byte layout.
package pmem_loader_pkg;

   localparam int BYTE_W    = 8;
   localparam int HDR_BYTES = 4;   // ADDR_HI ADDR_LO CNT_HI CNT_LO
   localparam int CNT_W     = 16;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_ADDR_HI = 4'd1,
      ST_ADDR_LO = 4'd2,
      ST_CNT_HI  = 4'd3,
      ST_CNT_LO  = 4'd4,
      ST_DATA_HI = 4'd5,
      ST_DATA_LO = 4'd6,
      ST_CSUM    = 4'd7,
      ST_DONE    = 4'd8,
      ST_ERROR   = 4'd9
   } ld_state_e;

   // Receiving states are contiguous in the encoding, so a range check suffices.
   function automatic logic st_receiving(ld_state_e s);
      return (s >= ST_ADDR_HI) && (s <= ST_CSUM);
   endfunction

   function automatic logic st_can_start(ld_state_e s);
      return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERROR);
   endfunction

endpackage

// File: rtl/pmem_loader_csum.sv
// 8-bit XOR accumulator over accepted frame bytes; clear has priority over enable.
module pmem_loader_csum
   import pmem_loader_pkg::*;
(
   input  logic              clock_i,
   input  logic              reset_i,
   input  logic              clr_i,
   input  logic              en_i,
   input  logic [BYTE_W-1:0] byte_i,
   output logic [BYTE_W-1:0] sum_o
);

   logic [BYTE_W-1:0] sum_q, sum_d;

   always_comb begin
      sum_d = sum_q;
      if (clr_i)
         sum_d = '0;
      else if (en_i)
         sum_d = sum_q ^ byte_i;
   end

   always_ff @(posedge clock_i) begin
      if (!reset_i)
         sum_q <= '0;
      else
         sum_q <= sum_d;
   end

   assign sum_o = sum_q;

endmodule

// File: rtl/pmem_loader.sv
// Program-memory loader: parses a framed byte stream into pmem word writes and gates core reset.
module pmem_loader
   import pmem_loader_pkg::*;
#(
   parameter int PMEM_ADDR_WIDTH  = 12,
   parameter int PMEM_WORD_WIDTH  = 16,
   parameter int PC_INCREMENT     = 2,
   parameter int HOLD_AFTER_RESET = 1
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       in_start,
   input  logic [7:0]                 in_byte,
   input  logic                       in_byte_valid,
   output logic                       out_byte_ready,
   output logic                       out_pmem_wr_en,
   output logic [PMEM_ADDR_WIDTH-1:0] out_pmem_wr_addr,
   output logic [PMEM_WORD_WIDTH-1:0] out_pmem_wr_word,
   output logic                       out_cpu_hold,
   output logic                       out_busy,
   output logic                       out_done,
   output logic                       out_error
);

   localparam logic HOLD_RST = (HOLD_AFTER_RESET != 0);

   ld_state_e                  state_q, state_d;
   logic [BYTE_W-1:0]          addr_hi_q, addr_hi_d;
   logic [PMEM_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic [BYTE_W-1:0]          data_hi_q, data_hi_d;
   logic                       wr_en_q, wr_en_d;
   logic [PMEM_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [PMEM_WORD_WIDTH-1:0] wr_word_q, wr_word_d;
   logic                       hold_q, hold_d;

   logic                       accept;
   logic                       csum_clr;
   logic                       csum_en;
   logic [BYTE_W-1:0]          csum;

   assign out_byte_ready = st_receiving(state_q);
   assign accept         = in_byte_valid && out_byte_ready;
   // The checksum byte itself is compared, never folded into the running sum.
   assign csum_en        = accept && (state_q != ST_CSUM);

   pmem_loader_csum u_csum (
      .clock_i (clock),
      .reset_i (reset),
      .clr_i   (csum_clr),
      .en_i    (csum_en),
      .byte_i  (in_byte),
      .sum_o   (csum)
   );

   always_comb begin
      state_d   = state_q;
      addr_hi_d = addr_hi_q;
      addr_d    = addr_q;
      cnt_d     = cnt_q;
      data_hi_d = data_hi_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_word_d = wr_word_q;
      hold_d    = hold_q;
      csum_clr  = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (in_start) begin
               state_d  = ST_ADDR_HI;
               hold_d   = 1'b1;
               csum_clr = 1'b1;
            end
         end
         ST_ADDR_HI: if (accept) begin
            addr_hi_d = in_byte;
            state_d   = ST_ADDR_LO;
         end
         ST_ADDR_LO: if (accept) begin
            addr_d  = PMEM_ADDR_WIDTH'({addr_hi_q, in_byte});
            state_d = ST_CNT_HI;
         end
         ST_CNT_HI: if (accept) begin
            cnt_d   = {in_byte, cnt_q[7:0]};
            state_d = ST_CNT_LO;
         end
         ST_CNT_LO: if (accept) begin
            cnt_d   = {cnt_q[15:8], in_byte};
            state_d = ({cnt_q[15:8], in_byte} == '0) ? ST_CSUM : ST_DATA_HI;
         end
         ST_DATA_HI: if (accept) begin
            data_hi_d = in_byte;
            state_d   = ST_DATA_LO;
         end
         ST_DATA_LO: if (accept) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_word_d = {data_hi_q, in_byte};
            addr_d    = addr_q + PMEM_ADDR_WIDTH'(PC_INCREMENT);
            cnt_d     = cnt_q - 1'b1;
            state_d   = (cnt_q == CNT_W'(1)) ? ST_CSUM : ST_DATA_HI;
         end
         ST_CSUM: if (accept) begin
            if (in_byte == csum) begin
               state_d = ST_DONE;
               hold_d  = 1'b0;
            end else begin
               state_d = ST_ERROR;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         addr_hi_q <= '0;
         addr_q    <= '0;
         cnt_q     <= '0;
         data_hi_q <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_word_q <= '0;
         hold_q    <= HOLD_RST;
      end else begin
         state_q   <= state_d;
         addr_hi_q <= addr_hi_d;
         addr_q    <= addr_d;
         cnt_q     <= cnt_d;
         data_hi_q <= data_hi_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_word_q <= wr_word_d;
         hold_q    <= hold_d;
      end
   end

   assign out_pmem_wr_en   = wr_en_q;
   assign out_pmem_wr_addr = wr_addr_q;
   assign out_pmem_wr_word = wr_word_q;
   assign out_cpu_hold     = hold_q;
   assign out_busy         = st_receiving(state_q);
   assign out_done         = (state_q == ST_DONE);
   assign out_error        = (state_q == ST_ERROR);

endmodule
